// File: rtl/tmg_pkg.sv
// rtl/tmg_pkg.sv - shared widths, saturation limit and FSM states for timing_metric_gen
package tmg_pkg;
  localparam int TMG_SAMP_W = 16;
  localparam int TMG_IDX_W  = 13;
  localparam int TMG_MET_W  = 36;
  localparam logic [TMG_MET_W-1:0] TMG_SAT = 36'hFFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_ACCUM,
    ST_DRAIN,
    ST_CLEAR,
    ST_DUMP
  } tmg_state_e;
endpackage

// File: rtl/tmg_diff_sq.sv
// rtl/tmg_diff_sq.sv - registered slope-energy stage: m = (x.i-prev.i)^2 + (x.q-prev.q)^2
module tmg_diff_sq import tmg_pkg::*; #(
  parameter int PH_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prime,
  input  logic                  accum,
  input  logic [TMG_SAMP_W-1:0] x_i,
  input  logic [TMG_SAMP_W-1:0] x_q,
  input  logic [PH_W-1:0]       phase,
  output logic [32:0]           m,
  output logic                  m_valid,
  output logic [PH_W-1:0]       m_phase
);
  logic [TMG_SAMP_W-1:0] prev_i_q, prev_i_d, prev_q_q, prev_q_d;
  logic [32:0]           m_q, m_d;
  logic                  m_valid_q, m_valid_d;
  logic [PH_W-1:0]       m_phase_q, m_phase_d;

  logic [16:0]        di, dq;
  logic signed [33:0] di_x, dq_x, sq_i, sq_q;

  always_comb begin
    prev_i_d  = prev_i_q;
    prev_q_d  = prev_q_q;
    m_d       = m_q;
    m_valid_d = 1'b0;
    m_phase_d = m_phase_q;
    // Sign-extend to 17b before subtracting so full-scale swings cannot wrap.
    di   = {x_i[15], x_i} - {prev_i_q[15], prev_i_q};
    dq   = {x_q[15], x_q} - {prev_q_q[15], prev_q_q};
    di_x = $signed({{17{di[16]}}, di});
    dq_x = $signed({{17{dq[16]}}, dq});
    sq_i = di_x * di_x;
    sq_q = dq_x * dq_x;
    if (prime || accum) begin
      prev_i_d = x_i;
      prev_q_d = x_q;
    end
    if (accum) begin
      m_d       = 33'(sq_i + sq_q);
      m_valid_d = 1'b1;
      m_phase_d = phase;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_i_q  <= '0;
      prev_q_q  <= '0;
      m_q       <= '0;
      m_valid_q <= 1'b0;
      m_phase_q <= '0;
    end else begin
      prev_i_q  <= prev_i_d;
      prev_q_q  <= prev_q_d;
      m_q       <= m_d;
      m_valid_q <= m_valid_d;
      m_phase_q <= m_phase_d;
    end
  end

  assign m       = m_q;
  assign m_valid = m_valid_q;
  assign m_phase = m_phase_q;
endmodule

// File: rtl/timing_metric_gen.sv
// rtl/timing_metric_gen.sv - per-phase slope-energy accumulation and dump to the min finder
// Optional TMG_SAT_FLAG_EN adds a sticky sat_flag output.
module timing_metric_gen import tmg_pkg::*; #(
  parameter int OSR  = 8,
  parameter int NSYM = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [TMG_SAMP_W-1:0] s_i,
  input  logic [TMG_SAMP_W-1:0] s_q,
  output logic                  busy,
  output logic                  mf_clr,
  output logic                  out_en,
  output logic [TMG_IDX_W-1:0]  out_idx,
  output logic [TMG_MET_W-1:0]  out_metric,
`ifdef TMG_SAT_FLAG_EN
  output logic                  sat_flag,
`endif
  output logic                  done
);
  localparam int PH_W  = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int SYM_W = $clog2(NSYM + 1);

  tmg_state_e state_q, state_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [SYM_W-1:0]     sym_q, sym_d;
  logic                 done_q, done_d;
  logic [TMG_MET_W-1:0] acc_q [OSR];
  logic [TMG_MET_W-1:0] acc_d [OSR];

  logic            start_acc, prime_en, accum_en;
  logic [32:0]     m;
  logic            m_valid, sat;
  logic [PH_W-1:0] m_phase;
  logic [36:0]     sum;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign prime_en  = (state_q == ST_PRIME) && s_valid;
  assign accum_en  = (state_q == ST_ACCUM) && s_valid;

  tmg_diff_sq #(.PH_W(PH_W)) u_diff_sq (
    .clk     (clk),
    .rst_n   (rst_n),
    .prime   (prime_en),
    .accum   (accum_en),
    .x_i     (s_i),
    .x_q     (s_q),
    .phase   (phase_q),
    .m       (m),
    .m_valid (m_valid),
    .m_phase (m_phase)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    sym_d   = sym_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PRIME;
          phase_d = '0;
          sym_d   = '0;
        end
      end
      ST_PRIME: if (s_valid) state_d = ST_ACCUM;
      ST_ACCUM: begin
        if (s_valid) begin
          if (phase_q == PH_W'(OSR - 1)) begin
            phase_d = '0;
            sym_d   = sym_q + 1'b1;
            if (sym_q == SYM_W'(NSYM - 1)) state_d = ST_DRAIN;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      // One cycle lets the final registered square land in its accumulator.
      ST_DRAIN: state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_DUMP;
      ST_DUMP: begin
        if (phase_q == PH_W'(OSR - 1)) begin
          phase_d = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sum = {1'b0, acc_q[m_phase]} + {4'd0, m};
    sat = (sum >= {1'b0, TMG_SAT});
    for (int p = 0; p < OSR; p++) acc_d[p] = start_acc ? '0 : acc_q[p];
    if (m_valid) acc_d[m_phase] = sat ? TMG_SAT : sum[TMG_MET_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      sym_q   <= '0;
      done_q  <= 1'b0;
      for (int p = 0; p < OSR; p++) acc_q[p] <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      sym_q   <= sym_d;
      done_q  <= done_d;
      for (int p = 0; p < OSR; p++) acc_q[p] <= acc_d[p];
    end
  end

`ifdef TMG_SAT_FLAG_EN
  logic sat_flag_q, sat_flag_d;

  always_comb begin
    sat_flag_d = start_acc ? 1'b0 : (sat_flag_q | (m_valid & sat));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sat_flag_q <= 1'b0;
    else        sat_flag_q <= sat_flag_d;
  end

  assign sat_flag = sat_flag_q;
`endif

  assign mf_clr     = (state_q == ST_CLEAR);
  assign out_en     = (state_q == ST_DUMP);
  assign out_idx    = out_en ? {{(TMG_IDX_W - PH_W){1'b0}}, phase_q} : '0;
  assign out_metric = out_en ? acc_q[phase_q] : '0;
  assign busy       = (state_q != ST_IDLE) || done_q;
  assign done       = done_q;
endmodule

// File: tb/tb_timing_metric_gen.sv
// tb/tb_timing_metric_gen.sv - directed scoreboard bench; dut_a OSR=4/NSYM=2, dut_b OSR=4/NSYM=16
module tb_timing_metric_gen;
  localparam logic [35:0] SAT = 36'hFFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n, start_a, start_b, s_valid;
  logic [15:0] s_i, s_q;
  logic        busy_a, clr_a, en_a, done_a, busy_b, clr_b, en_b, done_b;
  logic [12:0] idx_a, idx_b;
  logic [35:0] met_a, met_b;
`ifdef TMG_SAT_FLAG_EN
  logic        sat_a, sat_b;
`endif

  always #5 clk = ~clk;

  timing_metric_gen #(.OSR(4), .NSYM(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .s_valid(s_valid), .s_i(s_i), .s_q(s_q),
    .busy(busy_a), .mf_clr(clr_a), .out_en(en_a), .out_idx(idx_a), .out_metric(met_a),
`ifdef TMG_SAT_FLAG_EN
    .sat_flag(sat_a),
`endif
    .done(done_a));

  timing_metric_gen #(.OSR(4), .NSYM(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .s_valid(s_valid), .s_i(s_i), .s_q(s_q),
    .busy(busy_b), .mf_clr(clr_b), .out_en(en_b), .out_idx(idx_b), .out_metric(met_b),
`ifdef TMG_SAT_FLAG_EN
    .sat_flag(sat_b),
`endif
    .done(done_b));

  typedef struct packed {
    logic [12:0] idx;
    logic [35:0] met;
  } exp_t;

  exp_t exp_q[$];
  int   vi[$], vq[$];
  int   total = 0, bad = 0, done_cnt = 0;
  logic prev_en = 1'b0, prev_clr = 1'b0;
  logic [12:0] prev_idx = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Only one DUT is ever active, and idle outputs are zero, so OR-merging is safe.
  always @(negedge clk) begin
    logic m_en, m_clr, m_done;
    logic [12:0] m_idx;
    logic [35:0] m_met;
    exp_t e;
    m_en = en_a | en_b; m_clr = clr_a | clr_b; m_done = done_a | done_b;
    m_idx = idx_a | idx_b; m_met = met_a | met_b;
    if (m_done) begin
      chk("done_after_last", 64'({prev_en, prev_idx}), 64'({1'b1, 13'd3}));
      done_cnt++;
    end
    if (m_en) begin
      if (m_idx == 13'd0) chk("clr_before_dump", 64'(prev_clr), 64'd1);
      if (exp_q.size() == 0) begin
        chk("spurious_out_en", 64'(m_idx), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("out_idx", 64'(m_idx), 64'(e.idx));
        chk("out_metric", 64'(m_met), 64'(e.met));
      end
    end
    prev_en = m_en; prev_clr = m_clr; prev_idx = m_idx;
  end

  task automatic push4(input logic [35:0] m0, m1, m2, m3);
    exp_q.push_back({13'd0, m0});
    exp_q.push_back({13'd1, m1});
    exp_q.push_back({13'd2, m2});
    exp_q.push_back({13'd3, m3});
  endtask

  task automatic pulse_start(input bit use_b, input bit with_sample);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    s_valid = with_sample; s_i = 16'd12345; s_q = 16'd777;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; s_valid = 1'b0;
  endtask

  task automatic build_const(input int n);
    vi.delete(); vq.delete();
    for (int k = 0; k < n; k++) begin vi.push_back(100); vq.push_back(-50); end
  endtask

  task automatic build_steps();
    int v, st[4];
    st = '{3, 1, 2, 4};
    vi.delete(); vq.delete();
    v = 0; vi.push_back(0); vq.push_back(0);
    for (int k = 0; k < 8; k++) begin v += st[k % 4]; vi.push_back(v); vq.push_back(0); end
  endtask

  task automatic send(input bit use_b, input int n, input int gap, input int mid_start_at);
    for (int k = 0; k < n; k++) begin
      s_valid = 1'b1; s_i = 16'(vi[k]); s_q = 16'(vq[k]);
      @(posedge clk); #1;
      s_valid = 1'b0;
      if (k == mid_start_at) pulse_start(use_b, 1'b0);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin @(posedge clk); #1; n++; end
    chk("done_timeout", 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic sweep(input bit use_b, input int gap, input int mid_start_at, input bit start_with_sample);
    int target;
    target = done_cnt + 1;
    pulse_start(use_b, start_with_sample);
    chk("busy_after_start", 64'(use_b ? busy_b : busy_a), 64'd1);
    send(use_b, vi.size(), gap, mid_start_at);
    wait_done(target);
  endtask

  initial begin
    int dc;
    longint acc[4];
    longint di, dq;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; s_valid = 1'b0; s_i = '0; s_q = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", 64'({busy_a, busy_b}), 64'd0);
    chk("rst_flags", 64'({clr_a, en_a, done_a, clr_b, en_b, done_b}), 64'd0);
    chk("rst_idx_met", 64'({idx_a, met_a}) | 64'({idx_b, met_b}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // constant input: zero slope energy everywhere
    build_const(9); push4(0, 0, 0, 0);
    sweep(1'b0, 0, -1, 1'b0);

    // per-phase I steps 3,1,2,4
    build_steps(); push4(18, 2, 8, 32);
    sweep(1'b0, 0, -1, 1'b0);
`ifdef TMG_SAT_FLAG_EN
    chk("sat_flag_clear", 64'(sat_a), 64'd0);
`endif

    // full-scale alternation on the NSYM=16 instance saturates every phase
    vi.delete(); vq.delete();
    for (int k = 0; k < 65; k++) begin
      vi.push_back((k % 2) ? -32768 : 32767);
      vq.push_back((k % 2) ? -32768 : 32767);
    end
    push4(SAT, SAT, SAT, SAT);
    sweep(1'b1, 0, -1, 1'b0);
`ifdef TMG_SAT_FLAG_EN
    chk("sat_flag_set", 64'(sat_b), 64'd1);
`endif

    // gaps, start during ACCUM, sample in the start cycle: same metrics, one sweep only
    build_steps(); push4(18, 2, 8, 32);
    sweep(1'b0, 3, 4, 1'b1);
    dc = done_cnt;
    repeat (20) begin @(posedge clk); #1; end
    chk("no_second_sweep", 64'(done_cnt), 64'(dc));
    chk("idle_after_sweep", 64'(busy_a), 64'd0);

    // reset mid-ACCUM aborts; the next sweep starts from clean accumulators
    build_steps();
    pulse_start(1'b0, 1'b0);
    send(1'b0, 5, 0, -1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("busy_after_reset", 64'(busy_a), 64'd0);
    dc = done_cnt;
    repeat (20) begin @(posedge clk); #1; end
    chk("no_done_after_abort", 64'(done_cnt), 64'(dc));
    build_const(9); push4(0, 0, 0, 0);
    sweep(1'b0, 0, -1, 1'b0);

    // back-to-back: random data modelled independently, then steps immediately after done
    vi.delete(); vq.delete();
    for (int k = 0; k < 9; k++) begin
      vi.push_back(int'($urandom_range(0, 4000)) - 2000);
      vq.push_back(int'($urandom_range(0, 4000)) - 2000);
    end
    acc = '{0, 0, 0, 0};
    for (int k = 1; k < 9; k++) begin
      di = longint'(vi[k] - vi[k-1]);
      dq = longint'(vq[k] - vq[k-1]);
      acc[(k - 1) % 4] += di * di + dq * dq;
    end
    push4(36'(acc[0]), 36'(acc[1]), 36'(acc[2]), 36'(acc[3]));
    sweep(1'b0, 1, -1, 1'b0);
    build_steps(); push4(18, 2, 8, 32);
    sweep(1'b0, 0, -1, 1'b0);

    repeat (5) begin @(posedge clk); #1; end
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("sweep_count", 64'(done_cnt), 64'd7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
